mips_operand_stage: RTL and testbench

Operand-fetch stage directly upstream of the MIPS ALU/result model. It accepts 32-bit instructions from the instruction sequencer and reads `rs_content` and `rt_content` from a 32x32 register file. It issues instruction plus operands downstream over a valid/ready handshake and commits results returned by the execute stage. A per-register pending scoreboard stalls issue on RAW and WAW hazards so every issued instruction carries architecturally correct operands.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mips_regfile.sv | 43 ++++
 rtl/mips_operand_stage.sv | 135 +++++++++++++
 tb/tb_mips_operand_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS operand-fetch stage: field slices,
// opcode/funct codes of the supported subset, and destination/legality helpers.
package mips_pkg;

  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 26;
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned RD_HI = 15;
  localparam int unsigned RD_LO = 11;
  localparam int unsigned FN_HI = 5;
  localparam int unsigned FN_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_BAD
  } instr_cls_e;

  function automatic instr_cls_e classify(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[OP_HI:OP_LO];
    fn = instr[FN_HI:FN_LO];
    classify = CLS_BAD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_ADD,
          FN_SUB, FN_AND, FN_OR, FN_SLTU: classify = CLS_R;
          default:                        classify = CLS_BAD;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI:            classify = CLS_I;
      default:                            classify = CLS_BAD;
    endcase
  endfunction

  function automatic logic is_legal(input logic [31:0] instr);
    is_legal = (classify(instr) != CLS_BAD);
  endfunction

  function automatic logic [4:0] dest_sel(input logic [31:0] instr);
    case (classify(instr))
      CLS_R:   dest_sel = instr[RD_HI:RD_LO];
      CLS_I:   dest_sel = instr[RT_HI:RT_LO];
      default: dest_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, register 0 hardwired to zero, asynchronous active-low clear.
module mips_regfile #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];

  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/mips_operand_stage.sv
// Operand-fetch stage with pending-register scoreboard (RAW/WAW stall) and a
// registered valid/ready output. Optional same-cycle writeback bypass: MIPS_WB_BYPASS_EN.
module mips_operand_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [DATA_W-1:0]  out_rs_content,
  output logic [DATA_W-1:0]  out_rt_content,
  output logic [4:0]         out_dest,
  output logic               out_illegal,
  input  logic               wb_valid,
  input  logic [4:0]         wb_dest,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [31:0]        pending_q, pending_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_instr_q, out_instr_d;
  logic [DATA_W-1:0]  out_rs_q, out_rs_d;
  logic [DATA_W-1:0]  out_rt_q, out_rt_d;
  logic [4:0]         out_dest_q, out_dest_d;
  logic               out_illegal_q, out_illegal_d;

  instr_cls_e        cls;
  logic [4:0]        rs, rt, dest;
  logic              wb_hit, hazard, accept;
  logic [31:0]       clr_mask, set_mask, pend_eff;
  logic [DATA_W-1:0] rf_rs, rf_rt, rs_val, rt_val;

  mips_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_hit),
    .waddr   (wb_dest),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rf_rs),
    .raddr_b (rt),
    .rdata_b (rf_rt)
  );

  always_comb begin
    cls      = classify(in_instr);
    rs       = in_instr[RS_HI:RS_LO];
    rt       = in_instr[RT_HI:RT_LO];
    dest     = dest_sel(in_instr);
    wb_hit   = wb_valid && (wb_dest != '0);
    clr_mask = wb_hit ? (32'h1 << wb_dest) : '0;
`ifdef MIPS_WB_BYPASS_EN
    // A commit landing this cycle already satisfies the dependency.
    pend_eff = pending_q & ~clr_mask;
    rs_val   = (wb_hit && (wb_dest == rs)) ? wb_data : rf_rs;
    rt_val   = (wb_hit && (wb_dest == rt)) ? wb_data : rf_rt;
`else
    pend_eff = pending_q;
    rs_val   = rf_rs;
    rt_val   = rf_rt;
`endif
    // Illegal words check no sources and have no destination.
    hazard = ((cls != CLS_BAD) && (rs != '0) && pend_eff[rs])
          || ((cls == CLS_R) && (rt != '0) && pend_eff[rt])
          || ((dest != '0) && pend_eff[dest]);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;

    set_mask = (accept && is_legal(in_instr) && (dest != '0)) ? (32'h1 << dest) : '0;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    stall_d = stall_q;
    if (in_valid && hazard && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end

    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_rs_d      = out_rs_q;
    out_rt_d      = out_rt_q;
    out_dest_d    = out_dest_q;
    out_illegal_d = out_illegal_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_instr_d   = in_instr;
      out_rs_d      = rs_val;
      out_rt_d      = rt_val;
      out_dest_d    = dest;
      out_illegal_d = (cls == CLS_BAD);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      stall_q       <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_dest_q    <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      stall_q       <= stall_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_rs_q      <= out_rs_d;
      out_rt_q      <= out_rt_d;
      out_dest_q    <= out_dest_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_rs_content = out_rs_q;
  assign out_rt_content = out_rt_q;
  assign out_dest       = out_dest_q;
  assign out_illegal    = out_illegal_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_mips_operand_stage.sv
// Directed self-checking bench for mips_operand_stage; expectations are
// hand-decoded from the instruction words. Handles MIPS_WB_BYPASS_EN either way.
module tb_mips_operand_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STALL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [DATA_W-1:0]  out_rs_content;
  logic [DATA_W-1:0]  out_rt_content;
  logic [4:0]         out_dest;
  logic               out_illegal;
  logic               wb_valid;
  logic [4:0]         wb_dest;
  logic [DATA_W-1:0]  wb_data;
  logic [STALL_W-1:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_stall;

  mips_operand_stage #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_rs_content (out_rs_content),
    .out_rt_content (out_rt_content),
    .out_dest       (out_dest),
    .out_illegal    (out_illegal),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_dest", 32'(out_dest), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // r8 <= 5, then addi $9,$8,3
    wb_valid = 1'b1; wb_dest = 5'd8; wb_data = 32'd5;
    tick();
    wb_valid = 1'b0;
    in_instr = 32'h21090003; in_valid = 1'b1;
    #1 check_eq("addi_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("addi_out_valid", 32'(out_valid), 32'd1);
    check_eq("addi_rs", out_rs_content, 32'd5);
    check_eq("addi_rt", out_rt_content, 32'd0);
    check_eq("addi_dest", 32'(out_dest), 32'd9);
    check_eq("addi_illegal", 32'(out_illegal), 32'd0);
    check_eq("addi_pend9", 32'(dut.pending_q[9]), 32'd1);

    // add $10,$9,$9 stalls on pending r9
    in_instr = 32'h01295020; in_valid = 1'b1;
    #1 check_eq("raw_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("raw_stall1", 32'(stall_cnt), 32'd1);
    check_eq("raw_out_drained", 32'(out_valid), 32'd0);
    wb_valid = 1'b1; wb_dest = 5'd9; wb_data = 32'd8;
    #1;
`ifdef MIPS_WB_BYPASS_EN
    check_eq("byp_in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    exp_stall = 1;
`else
    check_eq("nobyp_in_ready_n", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 check_eq("nobyp_in_ready_n1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    exp_stall = 2;
`endif
    check_eq("add_out_valid", 32'(out_valid), 32'd1);
    check_eq("add_rs", out_rs_content, 32'd8);
    check_eq("add_rt", out_rt_content, 32'd8);
    check_eq("add_dest", 32'(out_dest), 32'd10);
    check_eq("add_stall", 32'(stall_cnt), exp_stall);

    // write to r0 is discarded; ori $11,$0,0x1234
    wb_valid = 1'b1; wb_dest = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_valid = 1'b0;
    in_instr = 32'h340B1234; in_valid = 1'b1;
    #1 check_eq("r0_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("r0_rs", out_rs_content, 32'd0);
    check_eq("r0_dest", 32'(out_dest), 32'd11);
    check_eq("r0_stall", 32'(stall_cnt), exp_stall);

    // backpressure: and $12,$1,$2 offered while out_ready=0
    out_ready = 1'b0;
    in_instr = 32'h00226024; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_instr", out_instr, 32'h340B1234);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_stall", 32'(stall_cnt), exp_stall);
    end
    out_ready = 1'b1;
    #1 check_eq("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("release_instr", out_instr, 32'h00226024);
    check_eq("release_dest", 32'(out_dest), 32'd12);

    // lw is outside the supported set
    in_instr = 32'h8D090000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("lw_illegal", 32'(out_illegal), 32'd1);
    check_eq("lw_dest", 32'(out_dest), 32'd0);
    check_eq("lw_pending", dut.pending_q, 32'h0000_1C00);

    // add $13,$10,$0 stalls long enough to saturate the 4-bit counter
    in_instr = 32'h01406820; in_valid = 1'b1;
    repeat (20) tick();
    check_eq("sat_stall", 32'(stall_cnt), 32'd15);
    check_eq("sat_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // addi $9,$8,3 again, then reset mid-flight
    in_instr = 32'h21090003; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_rs", out_rs_content, 32'd5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_pending", dut.pending_q, 32'd0);
    check_eq("mid_rst_stall", 32'(stall_cnt), 32'd0);
    wb_valid = 1'b1; wb_dest = 5'd8; wb_data = 32'd77;
    repeat (2) tick();
    rst_n = 1'b1; wb_valid = 1'b0;
    in_instr = 32'h21090003; in_valid = 1'b1;
    #1 check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_r8", out_rs_content, 32'd0);
    check_eq("post_rst_dest", 32'(out_dest), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
